universal_register: RTL and testbench
=====================================

Name: universal_register

Overview:
- Parametrised successor to the plain load/clear register.
- A WIDTH-bit register with eight operating modes: hold, parallel load, logical shifts with serial input, rotates, and increment/decrement.
- Increment/decrement either wraps or saturates, selected by parameter.
- Registered carry and zero status flags.
- Used as the general accumulator/shifter building block in datapath labs; drives downstream ALU and serial-out logic.

Parameters:
- WIDTH, 8, data width in bits; legal range is 2 or more.
- SATURATE, 0, 0 = INC/DEC wrap modulo 2^WIDTH; 1 = INC/DEC clamp at all-ones / zero.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  operation enable; when low, all state holds regardless of mode.
- mode  input  3  operation select (encoding below).
- data_in  input  WIDTH  parallel load value.
- ser_in  input  1  serial bit entering on SHL (at bit 0) or SHR (at MSB).
- data_out  output  WIDTH  register contents.
- carry  output  1  registered shifted-out bit / carry / borrow.
- zero  output  1  registered flag; 1 when the next-state data equals 0.
- ser_out  output  1  combinational; SHL/ROL: data_out[WIDTH-1]; every other mode: data_out[0].

Behaviour:
- All state updates occur on the rising edge of clk.
- Reset is synchronous and active-high. rst=1 at an edge sets data_out=0, carry=0 and zero=1.
- rst has priority over en and mode, including mid-operation. There are no other resets.
- Priority order: rst > en=0 (hold everything) > mode.
- Latency: one cycle from the inputs to data_out and the flags. ser_out follows data_out combinationally.
- Mode encoding (en=1):
  - 000 HOLD: data, carry and zero unchanged.
  - 001 LOAD: data <= data_in; carry <= 0.
  - 010 SHL: data <= {data[W-2:0], ser_in}; carry <= data[W-1].
  - 011 SHR: data <= {ser_in, data[W-1:1]}; carry <= data[0].
  - 100 ROL: data <= {data[W-2:0], data[W-1]}; carry <= data[W-1]; ser_in ignored.
  - 101 ROR: data <= {data[0], data[W-1:1]}; carry <= data[0]; ser_in ignored.
  - 110 INC:
    - SATURATE=0: data <= data+1, with carry <= 1 only on the all-ones -> 0 wrap, else 0.
    - SATURATE=1: at all-ones, data holds and carry <= 1; else data+1 and carry <= 0.
  - 111 DEC:
    - SATURATE=0: data <= data-1, with carry (borrow) <= 1 only on the 0 -> all-ones wrap, else 0.
    - SATURATE=1: at 0, data holds and carry <= 1; else data-1 and carry <= 0.
- Arithmetic is unsigned WIDTH+1 bits; the extra bit forms carry/borrow.
- zero is updated on every edge where the data is written, from the next-state value.
  - It is unchanged in HOLD and when en=0.
  - It always equals (data_out==0) after any edge.
- The mode input is sampled only when en=1; X on mode while en=0 must not corrupt state.

Decomposition:
- Shared package reg_pkg holds the mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
- The package also holds the 3-bit mode width constant.
- Natural sub-module: universal_register_next, a combinational next-state/carry calculator (inputs data, mode, ser_in, data_in; outputs next data and next carry).
- The top level holds the flops, the rst/en priority and the zero flag.

Test Plan:
- Reset and enable: W=8, drive rst=1 for 1 edge with en=1, mode=LOAD, data_in=8'hFF -> data_out=8'h00, carry=0, zero=1. Then en=0, mode=LOAD -> data stays 8'h00.
- Load and shift: LOAD 8'hA5; SHL with ser_in=1 -> data_out=8'h4B, carry=1. Then SHR with ser_in=0 -> data_out=8'h25, carry=1. ser_out checked each cycle.
- Rotate over a full cycle: LOAD 8'h81, then 8 ROL edges -> back to 8'h81. The first ROL gives 8'h03, carry=1. ROR from 8'h81 gives 8'hC0, carry=1.
- Wrap, SATURATE=0:
  - LOAD 8'hFF, INC -> data_out=8'h00, carry=1, zero=1.
  - Then DEC -> data_out=8'hFF, carry=1, zero=0.
  - Then INC from 8'h10 -> 8'h11, carry=0.
- Saturate, SATURATE=1: LOAD 8'hFF, INC -> data_out holds 8'hFF, carry=1. LOAD 8'h00, DEC -> data_out holds 8'h00, carry=1, zero=1.
- Reset mid-operation: during a burst of INC edges starting at 8'h3E, assert rst on the third edge -> data_out=8'h00, carry=0, zero=1. The next INC gives 8'h01.

Source files
------------

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pkg
//  Description : Shared constants for the universal register: the mode-select
//                width and the encoding of the eight operating modes.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage : reg_pkg
`default_nettype wire

// File: rtl/universal_register_next.sv
`default_nettype none
// ============================================================================
//  Module      : universal_register_next
//  Description : Combinational next-state and carry calculator for the
//                universal register.
//  Ports       : data_i    - current register contents
//                mode_i    - operation select
//                ser_i     - serial input bit (SHL enters at bit 0, SHR at MSB)
//                load_i    - parallel load value
//                data_o    - next register contents
//                carry_o   - next carry / borrow / shifted-out bit
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_register_next
    import reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              ser_i,
    input  logic [WIDTH-1:0]  load_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              carry_o
);

    // Extra top bit captures carry out of the increment / borrow out of the
    // decrement.
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    assign inc_w = {1'b0, data_i} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, data_i} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        data_o  = data_i;
        carry_o = 1'b0;
        case (mode_i)
            MODE_LOAD: begin
                data_o  = load_i;
                carry_o = 1'b0;
            end
            MODE_SHL: begin
                data_o  = {data_i[WIDTH-2:0], ser_i};
                carry_o = data_i[WIDTH-1];
            end
            MODE_SHR: begin
                data_o  = {ser_i, data_i[WIDTH-1:1]};
                carry_o = data_i[0];
            end
            MODE_ROL: begin
                data_o  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
                carry_o = data_i[WIDTH-1];
            end
            MODE_ROR: begin
                data_o  = {data_i[0], data_i[WIDTH-1:1]};
                carry_o = data_i[0];
            end
            MODE_INC: begin
                carry_o = inc_w[WIDTH];
                // Saturating variant clamps at all-ones instead of wrapping.
                data_o  = (SATURATE && inc_w[WIDTH]) ? data_i : inc_w[WIDTH-1:0];
            end
            MODE_DEC: begin
                carry_o = dec_w[WIDTH];
                data_o  = (SATURATE && dec_w[WIDTH]) ? data_i : dec_w[WIDTH-1:0];
            end
            default: begin
                // HOLD: the top level does not write state in this mode.
                data_o  = data_i;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule : universal_register_next
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_register
//  Description : WIDTH-bit register with hold, load, shift, rotate and
//                increment/decrement modes plus registered carry and zero.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                en       - operation enable (low = hold everything)
//                mode     - operation select
//                data_in  - parallel load value
//                ser_in   - serial input bit for SHL/SHR
//                data_out - register contents
//                carry    - registered carry / borrow / shifted-out bit
//                zero     - registered flag, 1 when data_out is 0
//                ser_out  - SHL/ROL: data_out MSB, otherwise data_out LSB
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_register
    import reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              carry,
    output logic              zero,
    output logic              ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             carry_q;
    logic             carry_d;
    logic             zero_q;

    universal_register_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .data_i  (data_q),
        .mode_i  (mode),
        .ser_i   (ser_in),
        .load_i  (data_in),
        .data_o  (data_d),
        .carry_o (carry_d)
    );

    // mode is only consulted when en is high, so an undriven mode while
    // disabled cannot reach the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (en) begin
            if (mode != MODE_HOLD) begin
                data_q  <= data_d;
                carry_q <= carry_d;
                zero_q  <= (data_d == '0);
            end
        end
    end

    assign data_out = data_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign ser_out  = ((mode == MODE_SHL) || (mode == MODE_ROL)) ? data_q[WIDTH-1]
                                                                 : data_q[0];

endmodule : universal_register
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_register
//  Description : Scoreboard bench for universal_register. Drives a wrapping
//                and a saturating 8-bit instance with the same stimulus and
//                compares both against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] data_in;
    logic         ser_in;

    logic [W-1:0] dout0, dout1;
    logic         car0, car1, zer0, zer1, so0, so1;

    always #5 clk = ~clk;

    universal_register #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
        .ser_in(ser_in), .data_out(dout0), .carry(car0), .zero(zer0),
        .ser_out(so0)
    );

    universal_register #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
        .ser_in(ser_in), .data_out(dout1), .carry(car1), .zero(zer1),
        .ser_out(so1)
    );

    typedef struct {
        int d;
        int c;
        int z;
    } st_t;

    typedef struct {
        st_t s0;
        st_t s1;
        int  so0;
        int  so1;
    } exp_t;

    exp_t q[$];
    st_t  m0, m1;
    int   checks = 0;
    int   errors = 0;

    // Reference model expressed with plain integer arithmetic on 0..255.
    function automatic st_t model(st_t s, bit sat, bit r, bit e, int md,
                                  int din, int ser);
        st_t n = s;
        int  v = s.d;
        int  nv = v;
        int  c = 0;
        if (r) begin
            n.d = 0; n.c = 0; n.z = 1;
            return n;
        end
        if (!e || md == 0) return n;
        case (md)
            1: begin nv = din; c = 0; end
            2: begin nv = (v * 2 + ser) % 256; c = v / 128; end
            3: begin nv = ser * 128 + v / 2; c = v % 2; end
            4: begin nv = (v * 2) % 256 + v / 128; c = v / 128; end
            5: begin nv = (v % 2) * 128 + v / 2; c = v % 2; end
            6: begin
                if (v == 255) begin nv = sat ? 255 : 0; c = 1; end
                else begin nv = v + 1; c = 0; end
            end
            default: begin
                if (v == 0) begin nv = sat ? 0 : 255; c = 1; end
                else begin nv = v - 1; c = 0; end
            end
        endcase
        n.d = nv; n.c = c; n.z = (nv == 0) ? 1 : 0;
        return n;
    endfunction

    function automatic int ser_exp(int md, int d);
        return (md == 2 || md == 4) ? d / 128 : d % 2;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus on the falling edge and queues the
    // response expected after the following rising edge.
    task automatic step(bit r, bit e, int md, int din, int ser);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = md[2:0]; data_in = din[W-1:0]; ser_in = ser[0];
        m0 = model(m0, 1'b0, r, e, md, din, ser);
        m1 = model(m1, 1'b1, r, e, md, din, ser);
        x.s0 = m0; x.s1 = m1;
        x.so0 = ser_exp(md, m0.d);
        x.so1 = ser_exp(md, m1.d);
        q.push_back(x);
    endtask

    // Monitor: every output sample is compared against the oldest expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("wrap.data",  int'(dout0), x.s0.d);
            chk("wrap.carry", int'(car0),  x.s0.c);
            chk("wrap.zero",  int'(zer0),  x.s0.z);
            chk("wrap.ser",   int'(so0),   x.so0);
            chk("sat.data",   int'(dout1), x.s1.d);
            chk("sat.carry",  int'(car1),  x.s1.c);
            chk("sat.zero",   int'(zer1),  x.s1.z);
            chk("sat.ser",    int'(so1),   x.so1);
        end
    end

    initial begin
        m0 = '{d: 0, c: 0, z: 1};
        m1 = '{d: 0, c: 0, z: 1};
        rst = 1'b1; en = 1'b0; mode = 3'd0; data_in = '0; ser_in = 1'b0;

        // Reset dominates a load, then disabled load keeps zero.
        step(1, 1, 1, 'hFF, 0);
        step(0, 0, 1, 'hFF, 0);
        // Load and shift.
        step(0, 1, 1, 'hA5, 0);
        step(0, 1, 2, 0, 1);
        step(0, 1, 3, 0, 0);
        // Full rotate cycle, then ROR.
        step(0, 1, 1, 'h81, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 4, 0, 1);
        step(0, 1, 5, 0, 0);
        // Wrap / saturate boundaries.
        step(0, 1, 1, 'hFF, 0);
        step(0, 1, 6, 0, 0);
        step(0, 1, 7, 0, 0);
        step(0, 1, 1, 'h00, 0);
        step(0, 1, 7, 0, 0);
        step(0, 1, 1, 'h10, 0);
        step(0, 1, 6, 0, 0);
        // Hold mode and en=0 with assorted modes.
        step(0, 1, 0, 'h55, 1);
        step(0, 0, 6, 'h55, 1);
        step(0, 0, 2, 'h55, 1);
        // Reset in the middle of an INC burst.
        step(0, 1, 1, 'h3E, 0);
        step(0, 1, 6, 0, 0);
        step(0, 1, 6, 0, 0);
        step(1, 1, 6, 0, 0);
        step(0, 1, 6, 0, 0);
        // Randomised traffic, biased toward the extremes of the value range.
        for (int i = 0; i < 400; i++) begin
            int r, e, md, din;
            r   = ($urandom_range(0, 49) == 0) ? 1 : 0;
            e   = ($urandom_range(0, 7) == 0) ? 0 : 1;
            md  = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: din = 0;
                1: din = 255;
                default: din = $urandom_range(0, 255);
            endcase
            step(r[0], e[0], md, din, $urandom_range(0, 1));
        end

        repeat (3) @(negedge clk);
        chk("queue.drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_universal_register
`default_nettype wire
